aes_ss_stim: RTL and testbench
==============================

AES_SS_STIM -- requirements
Module: aes_ss_stim

Interface
REQ-001 SHALL have parameter DW, default 64: cipher state and key width in bits (small-scale AES 4x4x4).
REQ-002 SHALL have parameter RW, default 360: width of the DUT fresh-randomness bus.
REQ-003 SHALL have parameter TMO, default 255: timeout in cycles while waiting for DUT completion.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports go  input  1 (pulse: start campaign), mode  input  1 (0 fixed plaintext, 1 ciphertext chaining), n_runs  input  16 (encryptions per campaign).
REQ-007 SHALL have ports key  input  DW, pt  input  DW, exp  input  DW (expected ciphertext), seed  input  64 (PRNG seed).
REQ-008 SHALL have DUT-side ports dut_start  output  1, dut_text  output  DW, dut_tmask  output  DW, dut_key  output  DW, dut_kmask  output  DW, dut_rbits  output  RW, dut_out  input  DW, dut_done  input  1.
REQ-009 SHALL have status ports busy  output  1, done  output  1 (one-cycle pulse), pass  output  1, err_cnt  output  16, run_cnt  output  16, tmo_flag  output  1.

Function
REQ-010 SHALL use the FSM states IDLE, FILL, START, WAIT, CHECK, FIN; busy is high in every state except IDLE.
REQ-011 SHALL, in IDLE on go=1, latch key, pt, exp, mode and n_runs, clear err_cnt, run_cnt and tmo_flag, load the PRNG with seed (seed=0 replaced by 64'h9E3779B97F4A7C15), and enter FILL; if n_runs=0, it SHALL enter FIN directly with pass=1 and no dut_start.
REQ-012 SHALL ignore go outside IDLE.
REQ-013 SHALL use an xorshift64 PRNG (x^=x<<13; x^=x>>7; x^=x<<17) that advances once per cycle in FILL, START and WAIT.
REQ-014 SHALL shift 64 fresh PRNG bits per cycle into the RW-bit randomness register in FILL and WAIT; FILL lasts ceil(RW/64) cycles (6 at default).
REQ-015 SHALL, on the last FILL cycle, capture tmask and kmask from PRNG bits [DW-1:0] on consecutive draws; dut_text = cur_pt ^ tmask, dut_tmask = tmask, dut_key = key ^ kmask, dut_kmask = kmask, all held stable from START until CHECK.
REQ-016 SHALL assert dut_start for exactly one cycle in START, then enter WAIT with the timeout counter cleared.
REQ-017 SHALL leave WAIT on dut_done=1 and capture dut_out, or after TMO cycles without dut_done, setting tmo_flag and incrementing err_cnt; if both occur in the same cycle, dut_done SHALL take priority.
REQ-018 SHALL, in CHECK in mode 0, increment err_cnt when captured dut_out != exp; in mode 1, it SHALL compare only on the final run, and otherwise SHALL set cur_pt = captured dut_out for the next run.
REQ-019 SHALL increment run_cnt once per CHECK; it SHALL return to FILL while run_cnt < n_runs, and otherwise enter FIN.
REQ-020 SHALL saturate err_cnt at 16'hFFFF.
REQ-021 SHALL, in FIN, pulse done for one cycle, set pass = (err_cnt==0 and tmo_flag==0), and return to IDLE; pass, err_cnt, run_cnt and tmo_flag SHALL hold until the next accepted go.

Reset
REQ-022 SHALL, on rst_n=0 at any time including mid-campaign, force IDLE and drive dut_start=0, busy=0, done=0, pass=0, tmo_flag=0, err_cnt=0, run_cnt=0, and all dut_* data buses and the PRNG to 0.
REQ-023 SHALL resume normal operation on the first clock edge after rst_n deasserts, with no spurious dut_start.

Configuration
REQ-024 SHALL, with macro AES_SS_STIM_MASK_EN defined, behave as in REQ-013 to REQ-015.
REQ-025 SHALL, without AES_SS_STIM_MASK_EN, drive tmask, kmask and dut_rbits to constant 0 (unmasked run) and shorten FILL to one cycle, with all other behaviour unchanged.

Verification
REQ-026 SHALL cover: stub DUT (out = text^tmask^key^kmask, done 50 cycles after start), key=64'hFEDCBA9876543210, pt=0, exp=64'hFEDCBA9876543210, n_runs=1, mode 0 -> one dut_start pulse, done pulse, pass=1, err_cnt=0, run_cnt=1.
REQ-027 SHALL cover: same stub with exp=64'h0 and n_runs=4 -> err_cnt=4, pass=0, four dut_start pulses each at least 8 cycles apart.
REQ-028 SHALL cover: stub that never asserts dut_done, TMO=255 -> tmo_flag=1, err_cnt=1, done 256 cycles after START, pass=0.
REQ-029 SHALL cover: mode 1, key=64'h1, pt=0, n_runs=3, stub out = text^tmask^key^kmask, exp=64'h1 -> intermediate plaintexts 1 then 0, final out 1, pass=1.
REQ-030 SHALL cover: rst_n pulled low during WAIT, then go with n_runs=0 -> all outputs at reset values immediately, no dut_start, then an immediate done with pass=1.
REQ-031 SHALL cover: go asserted while busy, and seed=0 -> the second go is ignored, and dut_tmask is nonzero in MASK_EN builds and 0 otherwise.

Source files
------------

// File: rtl/aes_ss_stim.sv
// rtl/aes_ss_stim.sv - stimulus/checker campaign controller for a masked small-scale AES DUT
// Masking randomness (PRNG-driven tmask/kmask/rbits, multi-cycle FILL) enabled by AES_SS_STIM_MASK_EN.
module aes_ss_stim #(
  parameter int DW  = 64,
  parameter int RW  = 360,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          mode,
  input  logic [15:0]   n_runs,
  input  logic [DW-1:0] key,
  input  logic [DW-1:0] pt,
  input  logic [DW-1:0] exp,
  input  logic [63:0]   seed,
  output logic          dut_start,
  output logic [DW-1:0] dut_text,
  output logic [DW-1:0] dut_tmask,
  output logic [DW-1:0] dut_key,
  output logic [DW-1:0] dut_kmask,
  output logic [RW-1:0] dut_rbits,
  input  logic [DW-1:0] dut_out,
  input  logic          dut_done,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic [15:0]   run_cnt,
  output logic          tmo_flag
);

`ifdef AES_SS_STIM_MASK_EN
  localparam int FILL_N = (RW + 63) / 64;
`else
  localparam int FILL_N = 1;
`endif
  localparam int FW = (FILL_N > 1) ? $clog2(FILL_N) : 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [63:0] SEED_ALT = 64'h9E3779B97F4A7C15;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_START, S_WAIT, S_CHECK, S_FIN
  } state_t;

  state_t        state;
  logic [FW-1:0] fill_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [63:0]   prng_q;
  logic [63:0]   prng_n;
  logic [DW-1:0] cur_pt;
  logic [DW-1:0] key_q;
  logic [DW-1:0] exp_q;
  logic [DW-1:0] cap_q;
  logic          mode_q;
  logic [15:0]   nruns_q;
  logic          run_tmo;
  logic [DW-1:0] mask_t;
  logic [DW-1:0] mask_k;
  logic [15:0]   run_inc;
  logic          last_run;
  logic          miss;
  logic [15:0]   err_sat;

  function automatic logic [63:0] xs64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  assign prng_n = xs64(prng_q);
  assign busy   = (state != S_IDLE);

`ifdef AES_SS_STIM_MASK_EN
  logic [RW-1:0] rbits_q;
  // tmask uses the current draw, kmask the draw the PRNG is about to advance to
  assign mask_t    = prng_q[DW-1:0];
  assign mask_k    = prng_n[DW-1:0];
  assign dut_rbits = rbits_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbits_q <= '0;
    end else if (state == S_FILL || state == S_WAIT) begin
      rbits_q <= (rbits_q << 64) | RW'(prng_q);
    end
  end
`else
  assign mask_t    = '0;
  assign mask_k    = '0;
  assign dut_rbits = '0;
`endif

  assign run_inc  = run_cnt + 16'd1;
  assign last_run = (run_inc >= nruns_q);
  // timed-out runs were already charged in WAIT; chaining runs only compare at the end
  assign miss     = !run_tmo && (!mode_q || last_run) && (cap_q != exp_q);
  assign err_sat  = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fill_cnt  <= '0;
      tmo_cnt   <= '0;
      prng_q    <= '0;
      cur_pt    <= '0;
      key_q     <= '0;
      exp_q     <= '0;
      cap_q     <= '0;
      mode_q    <= 1'b0;
      nruns_q   <= '0;
      run_tmo   <= 1'b0;
      dut_start <= 1'b0;
      dut_text  <= '0;
      dut_tmask <= '0;
      dut_key   <= '0;
      dut_kmask <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      run_cnt   <= '0;
      tmo_flag  <= 1'b0;
    end else begin
      dut_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            key_q    <= key;
            cur_pt   <= pt;
            exp_q    <= exp;
            mode_q   <= mode;
            nruns_q  <= n_runs;
            err_cnt  <= '0;
            run_cnt  <= '0;
            tmo_flag <= 1'b0;
            run_tmo  <= 1'b0;
            fill_cnt <= '0;
            prng_q   <= (seed == 64'd0) ? SEED_ALT : seed;
            if (n_runs == 16'd0) begin
              pass  <= 1'b1;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              pass  <= 1'b0;
              state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          prng_q <= prng_n;
          if (fill_cnt == FW'(FILL_N - 1)) begin
            dut_tmask <= mask_t;
            dut_kmask <= mask_k;
            dut_text  <= cur_pt ^ mask_t;
            dut_key   <= key_q ^ mask_k;
            dut_start <= 1'b1;
            state     <= S_START;
          end else begin
            fill_cnt <= fill_cnt + FW'(1);
          end
        end
        S_START: begin
          prng_q  <= prng_n;
          tmo_cnt <= '0;
          run_tmo <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          prng_q <= prng_n;
          if (dut_done) begin
            cap_q <= dut_out;
            state <= S_CHECK;
          end else if (tmo_cnt == TW'(TMO - 1)) begin
            tmo_flag <= 1'b1;
            run_tmo  <= 1'b1;
            err_cnt  <= err_sat;
            state    <= S_CHECK;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_CHECK: begin
          run_cnt <= run_inc;
          if (miss) err_cnt <= err_sat;
          if (mode_q && !last_run && !run_tmo) cur_pt <= cap_q;
          if (last_run) begin
            done  <= 1'b1;
            pass  <= (err_cnt == 16'd0) && !miss && !tmo_flag;
            state <= S_FIN;
          end else begin
            fill_cnt <= '0;
            state    <= S_FILL;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_ss_stim.sv
// tb/tb_aes_ss_stim.sv - table-driven bench for aes_ss_stim with an xor stub DUT
// Mask expectations follow AES_SS_STIM_MASK_EN when the bench is built with it.
module tb_aes_ss_stim;
  localparam int DW  = 64;
  localparam int RW  = 360;
  localparam int TMO = 255;
`ifdef AES_SS_STIM_MASK_EN
  localparam int FILL_N = (RW + 63) / 64;
`else
  localparam int FILL_N = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          mode = 1'b0;
  logic [15:0]   n_runs = '0;
  logic [DW-1:0] key = '0, pt = '0, exp_v = '0;
  logic [63:0]   seed = '0;
  logic          dut_start;
  logic [DW-1:0] dut_text, dut_tmask, dut_key, dut_kmask;
  logic [RW-1:0] dut_rbits;
  logic [DW-1:0] dut_out = '0;
  logic          dut_done = 1'b0;
  logic          busy, done, pass, tmo_flag;
  logic [15:0]   err_cnt, run_cnt;

  aes_ss_stim #(.DW(DW), .RW(RW), .TMO(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .n_runs(n_runs),
    .key(key), .pt(pt), .exp(exp_v), .seed(seed),
    .dut_start(dut_start), .dut_text(dut_text), .dut_tmask(dut_tmask),
    .dut_key(dut_key), .dut_kmask(dut_kmask), .dut_rbits(dut_rbits),
    .dut_out(dut_out), .dut_done(dut_done),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .run_cnt(run_cnt), .tmo_flag(tmo_flag)
  );

  always #5 clk = ~clk;

  // stub: out = text^tmask^key^kmask, done 50 cycles after dut_start, or never when hung
  logic stub_hang = 1'b0;
  int   stub_cnt = -1;
  always @(posedge clk) begin
    dut_done <= 1'b0;
    if (dut_start) begin
      stub_cnt <= 48;
      dut_out  <= dut_text ^ dut_tmask ^ dut_key ^ dut_kmask;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end else if (stub_cnt == 0) begin
      dut_done <= !stub_hang;
      stub_cnt <= -1;
    end
  end

  int cyc = 0, n_starts = 0, n_dones = 0, last_start = -1, min_gap = 1000000;
  int start_cyc = 0, done_cyc = 0;
  logic [DW-1:0] pt_seen[$];
  logic [DW-1:0] tmask_seen, kmask_seen;
  logic [RW-1:0] rbits_seen;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dut_start) begin
      if (last_start >= 0 && cyc - last_start < min_gap) min_gap = cyc - last_start;
      last_start = cyc;
      start_cyc  = cyc;
      n_starts++;
      pt_seen.push_back(dut_text ^ dut_tmask);
      tmask_seen = dut_tmask;
      kmask_seen = dut_kmask;
      rbits_seen = dut_rbits;
    end
    if (done) begin
      n_dones++;
      done_cyc = cyc;
    end
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] xs64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  task automatic clear_mon();
    n_starts = 0; n_dones = 0; last_start = -1; min_gap = 1000000;
    pt_seen.delete();
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: no done pulse within %0d cycles", name, t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic launch(input logic m, input logic [15:0] n, input logic [63:0] k, p, e, s,
                        input logic hang);
    clear_mon();
    stub_hang = hang;
    @(negedge clk);
    mode = m; n_runs = n; key = k; pt = p; exp_v = e; seed = s; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  typedef struct {
    logic        m;
    logic [15:0] n;
    logic [63:0] k, p, e, s;
    logic        hang;
    logic [15:0] e_err, e_run;
    logic        e_pass, e_tmo;
    int          e_starts;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [63:0] x;
    logic [63:0] r_model;
    logic [RW-1:0] rb_model;
    logic [63:0] tm_exp, km_exp;

    tbl[0] = '{1'b0, 16'd1, 64'hFEDCBA9876543210, 64'h0, 64'hFEDCBA9876543210, 64'd1234, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0, 1};
    tbl[1] = '{1'b0, 16'd4, 64'hFEDCBA9876543210, 64'h0, 64'h0, 64'd55, 1'b0, 16'd4, 16'd4, 1'b0, 1'b0, 4};
    tbl[2] = '{1'b1, 16'd3, 64'h1, 64'h0, 64'h1, 64'd77, 1'b0, 16'd0, 16'd3, 1'b1, 1'b0, 3};
    tbl[3] = '{1'b1, 16'd3, 64'h1, 64'h0, 64'h0, 64'd78, 1'b0, 16'd1, 16'd3, 1'b0, 1'b0, 3};
    tbl[4] = '{1'b0, 16'd2, 64'h0123456789ABCDEF, 64'h0F0F0F0F0F0F0F0F, 64'h0E2C4A6886A4C2E0, 64'd9, 1'b0, 16'd0, 16'd2, 1'b1, 1'b0, 2};
    tbl[5] = '{1'b0, 16'd0, 64'h5, 64'h6, 64'h7, 64'd3, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 0};
    tbl[6] = '{1'b0, 16'd1, 64'h5, 64'h0, 64'h5, 64'd4, 1'b1, 16'd1, 16'd1, 1'b0, 1'b1, 1};
    tbl[7] = '{1'b0, 16'd2, 64'h5, 64'h0, 64'h5, 64'd5, 1'b1, 16'd2, 16'd2, 1'b0, 1'b1, 2};

    repeat (2) @(negedge clk);
    #1;
    check("rst busy/done/pass/tmo/start", {59'd0, busy, done, pass, tmo_flag, dut_start}, 64'd0);
    check("rst err_cnt", err_cnt, 64'd0);
    check("rst run_cnt", run_cnt, 64'd0);
    check("rst dut buses", dut_text | dut_tmask | dut_key | dut_kmask, 64'd0);
    check("rst rbits", {63'd0, |dut_rbits}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      launch(tbl[i].m, tbl[i].n, tbl[i].k, tbl[i].p, tbl[i].e, tbl[i].s, tbl[i].hang);
      wait_done($sformatf("row%0d done", i));
      check($sformatf("row%0d err_cnt", i), err_cnt, tbl[i].e_err);
      check($sformatf("row%0d run_cnt", i), run_cnt, tbl[i].e_run);
      check($sformatf("row%0d pass", i), pass, tbl[i].e_pass);
      check($sformatf("row%0d tmo_flag", i), tmo_flag, tbl[i].e_tmo);
      check($sformatf("row%0d starts", i), n_starts, tbl[i].e_starts);
      check($sformatf("row%0d done pulses", i), n_dones, 1);
      check($sformatf("row%0d busy after", i), busy, 1'b0);
      if (tbl[i].e_starts > 1)
        check($sformatf("row%0d start gap>=8", i), min_gap >= 8, 1'b1);
    end

    // mode-1 chaining: plaintexts 0, 1, 0 fed to the DUT, final out 1
    launch(1'b1, 16'd3, 64'h1, 64'h0, 64'h1, 64'd99, 1'b0);
    wait_done("chain done");
    check("chain pt count", pt_seen.size(), 3);
    if (pt_seen.size() == 3) begin
      check("chain pt0", pt_seen[0], 64'h0);
      check("chain pt1", pt_seen[1], 64'h1);
      check("chain pt2", pt_seen[2], 64'h0);
    end
    check("chain pass", pass, 1'b1);

    // timeout: WAIT lasts TMO cycles, then CHECK, then FIN carries done
    launch(1'b0, 16'd1, 64'h5, 64'h0, 64'h5, 64'd6, 1'b1);
    wait_done("tmo done");
    check("tmo done latency", done_cyc - (start_cyc + 1), TMO + 1);
    check("tmo err_cnt", err_cnt, 64'd1);

    // second go while busy is ignored; seed 0 falls back to the fixed constant
    launch(1'b0, 16'd1, 64'hFEDCBA9876543210, 64'h0, 64'hFEDCBA9876543210, 64'd0, 1'b0);
    repeat (10) @(negedge clk);
    mode = 1'b1; n_runs = 16'd5; key = 64'h1; exp_v = 64'h2; seed = 64'd7; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done("busy-go done");
    check("busy-go run_cnt", run_cnt, 64'd1);
    check("busy-go starts", n_starts, 1);
    check("busy-go pass", pass, 1'b1);
    x = 64'h9E3779B97F4A7C15;
    rb_model = '0;
    for (int j = 0; j < FILL_N; j++) begin
      rb_model = (rb_model << 64) | RW'(x);
      r_model = x;
      x = xs64(x);
    end
`ifdef AES_SS_STIM_MASK_EN
    tm_exp = r_model;
    km_exp = x;
`else
    tm_exp = 64'd0;
    km_exp = 64'd0;
    rb_model = '0;
`endif
    check("seed0 tmask", tmask_seen, tm_exp);
    check("seed0 kmask", kmask_seen, km_exp);
    check("seed0 rbits", {63'd0, rbits_seen == rb_model}, 64'd1);

    // reset during WAIT, then an empty campaign
    launch(1'b0, 16'd1, 64'h5, 64'h0, 64'h5, 64'd8, 1'b1);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst flags", {59'd0, busy, done, pass, tmo_flag, dut_start}, 64'd0);
    check("midrst counters", {err_cnt, run_cnt}, 64'd0);
    check("midrst dut buses", dut_text | dut_tmask | dut_key | dut_kmask, 64'd0);
    check("midrst rbits", {63'd0, |dut_rbits}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    @(negedge clk);
    n_runs = 16'd0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("n0 immediate done", done, 1'b1);
    check("n0 pass", pass, 1'b1);
    repeat (5) @(negedge clk);
    check("n0 no dut_start", n_starts, 0);
    check("n0 idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
